// File: rtl/contador_universal_limites.sv
`default_nettype none
// ============================================================================
// Module   : contador_universal_limites
// Purpose  : N-bit up/down counter with runtime-programmable inclusive lower
//            and upper limits, programmable step and per-cycle wrap/saturate
//            selection. Provides a registered boundary-event pulse and a
//            sticky overflow flag for cascading and status reporting.
// Ports    : clock_clk_in  - clock, rising edge
//            reset_rst_in  - asynchronous active-high reset
//            syn_clr_in    - synchronous clear (highest priority)
//            load_in       - synchronous load of d_in (unclamped)
//            en_in         - count enable
//            up_in         - 1 = count up, 0 = count down
//            mode_in       - 0 = wrap, 1 = saturate at the limits
//            d_in          - load value
//            lim_lo_in     - lower limit, inclusive
//            lim_hi_in     - upper limit, inclusive
//            step_in       - count step magnitude
//            q_o           - registered counter value
//            max_tick_o    - q_o == lim_hi_in (combinational)
//            min_tick_o    - q_o == lim_lo_in (combinational)
//            bnd_o         - one-cycle boundary-event pulse (registered)
//            ovf_o         - sticky boundary-event flag (registered)
//            cfg_err_o     - lim_lo_in > lim_hi_in (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module contador_universal_limites #(
    parameter int N = 6,
    parameter int S = 6
) (
    input  logic         clock_clk_in,
    input  logic         reset_rst_in,
    input  logic         syn_clr_in,
    input  logic         load_in,
    input  logic         en_in,
    input  logic         up_in,
    input  logic         mode_in,
    input  logic [N-1:0] d_in,
    input  logic [N-1:0] lim_lo_in,
    input  logic [N-1:0] lim_hi_in,
    input  logic [S-1:0] step_in,
    output logic [N-1:0] q_o,
    output logic         max_tick_o,
    output logic         min_tick_o,
    output logic         bnd_o,
    output logic         ovf_o,
    output logic         cfg_err_o
);

    // Two guard bits: one absorbs the carry of q + step, the other acts as
    // the sign of q - step so that an underflow compares below lo.
    localparam int c_EW  = N + 2;
    localparam int c_PAD = c_EW - S;

    logic [N-1:0]       r_q;
    logic               r_bnd;
    logic               r_ovf;

    logic [c_EW-1:0]    w_q_ext;
    logic [c_EW-1:0]    w_step_ext;
    logic [c_EW-1:0]    w_lo_ext;
    logic [c_EW-1:0]    w_hi_ext;
    logic [c_EW-1:0]    w_sum;
    logic [c_EW-1:0]    w_diff;
    logic               w_cfg_err;
    logic               w_count;
    logic               w_event;
    logic [N-1:0]       w_q_count;

    assign w_q_ext    = {2'b00, r_q};
    assign w_step_ext = {{c_PAD{1'b0}}, step_in};
    assign w_lo_ext   = {2'b00, lim_lo_in};
    assign w_hi_ext   = {2'b00, lim_hi_in};
    assign w_sum      = w_q_ext + w_step_ext;
    assign w_diff     = w_q_ext - w_step_ext;

    assign w_cfg_err  = (lim_lo_in > lim_hi_in);
    assign w_count    = en_in && (step_in != '0) && !w_cfg_err;

    // Next value for a counting cycle. Any result leaving [lo,hi] in the
    // direction of travel is an event, including q already past the limit.
    always_comb begin
        w_event   = 1'b0;
        w_q_count = r_q;
        if (up_in) begin
            if (w_sum > w_hi_ext) begin
                w_event   = 1'b1;
                w_q_count = mode_in ? lim_hi_in : lim_lo_in;
            end else begin
                w_q_count = w_sum[N-1:0];
            end
        end else begin
            if ($signed(w_diff) < $signed(w_lo_ext)) begin
                w_event   = 1'b1;
                w_q_count = mode_in ? lim_lo_in : lim_hi_in;
            end else begin
                w_q_count = w_diff[N-1:0];
            end
        end
    end

    always_ff @(posedge clock_clk_in or posedge reset_rst_in) begin
        if (reset_rst_in) begin
            r_q   <= '0;
            r_bnd <= 1'b0;
            r_ovf <= 1'b0;
        end else if (syn_clr_in) begin
            r_q   <= '0;
            r_bnd <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load_in) begin
            r_q   <= d_in;
            r_bnd <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_count) begin
            r_q   <= w_q_count;
            r_bnd <= w_event;
            r_ovf <= r_ovf | w_event;
        end else begin
            r_bnd <= 1'b0;
        end
    end

    assign q_o        = r_q;
    assign bnd_o      = r_bnd;
    assign ovf_o      = r_ovf;
    assign cfg_err_o  = w_cfg_err;
    assign max_tick_o = (r_q == lim_hi_in);
    assign min_tick_o = (r_q == lim_lo_in);

endmodule
`default_nettype wire

// File: tb/tb_contador_universal_limites.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_universal_limites
// Purpose  : Directed self-checking bench for contador_universal_limites
//            (N=6, S=6) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_universal_limites;

    logic       clk = 1'b0;
    logic       rst;
    logic       syn_clr, load, en, up, mode;
    logic [5:0] d, lo, hi, step;
    logic [5:0] q;
    logic       max_tick, min_tick, bnd, ovf, cfg_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    contador_universal_limites #(.N(6), .S(6)) dut (
        .clock_clk_in (clk),
        .reset_rst_in (rst),
        .syn_clr_in   (syn_clr),
        .load_in      (load),
        .en_in        (en),
        .up_in        (up),
        .mode_in      (mode),
        .d_in         (d),
        .lim_lo_in    (lo),
        .lim_hi_in    (hi),
        .step_in      (step),
        .q_o          (q),
        .max_tick_o   (max_tick),
        .min_tick_o   (min_tick),
        .bnd_o        (bnd),
        .ovf_o        (ovf),
        .cfg_err_o    (cfg_err)
    );

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [5:0] v);
        load = 1'b1; d = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; syn_clr = 0; load = 0; en = 0; up = 1; mode = 0;
        d = 0; lo = 0; hi = 20; step = 1;
        tick(); tick();
        chk_cnt++; if (q !== 6'd0) $display("FAIL reset_q: got %0d expected 0", q); else pass_cnt++;
        chk_cnt++; if ({bnd, ovf} !== 2'b00) $display("FAIL reset_flags: got bnd/ovf %b expected 00", {bnd, ovf}); else pass_cnt++;
        chk_cnt++; if ({min_tick, max_tick} !== 2'b10) $display("FAIL reset_ticks: got min/max %b expected 10", {min_tick, max_tick}); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_up_wrap();
        lo = 10; hi = 20; step = 3; mode = 0; up = 1;
        do_load(15);
        chk_cnt++; if (q !== 6'd15) $display("FAIL upwrap_load: got %0d expected 15", q); else pass_cnt++;
        en = 1;
        tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd18, 2'b00}) $display("FAIL upwrap_18: got q=%0d bnd=%b ovf=%b expected 18 0 0", q, bnd, ovf); else pass_cnt++;
        tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd10, 2'b11}) $display("FAIL upwrap_10: got q=%0d bnd=%b ovf=%b expected 10 1 1", q, bnd, ovf); else pass_cnt++;
        tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd13, 2'b01}) $display("FAIL upwrap_13: got q=%0d bnd=%b ovf=%b expected 13 0 1", q, bnd, ovf); else pass_cnt++;
        en = 0;
    endtask

    task automatic test_up_sat();
        lo = 10; hi = 20; step = 3; mode = 1; up = 1;
        do_load(19);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if ({q, bnd, ovf, max_tick} !== {6'd20, 3'b111})
                $display("FAIL upsat_%0d: got q=%0d bnd=%b ovf=%b max=%b expected 20 1 1 1", i, q, bnd, ovf, max_tick);
            else pass_cnt++;
        end
        en = 0;
        do_load(12);
        chk_cnt++; if ({q, bnd, ovf} !== {6'd12, 2'b00}) $display("FAIL upsat_reload: got q=%0d bnd=%b ovf=%b expected 12 0 0", q, bnd, ovf); else pass_cnt++;
    endtask

    task automatic test_down_wrap();
        lo = 10; hi = 20; step = 3; mode = 0; up = 0;
        do_load(11);
        en = 1;
        tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd20, 2'b11}) $display("FAIL dnwrap_20: got q=%0d bnd=%b ovf=%b expected 20 1 1", q, bnd, ovf); else pass_cnt++;
        tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd17, 2'b01}) $display("FAIL dnwrap_17: got q=%0d bnd=%b ovf=%b expected 17 0 1", q, bnd, ovf); else pass_cnt++;
        en = 0;
    endtask

    task automatic test_full_range();
        lo = 0; hi = 63; step = 1; mode = 0; up = 1;
        do_load(63);
        en = 1;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd0, 1'b1}) $display("FAIL full_up: got q=%0d bnd=%b expected 0 1", q, bnd); else pass_cnt++;
        up = 0;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd63, 1'b1}) $display("FAIL full_dn: got q=%0d bnd=%b expected 63 1", q, bnd); else pass_cnt++;
        step = 0;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd63, 1'b0}) $display("FAIL step0_hold: got q=%0d bnd=%b expected 63 0", q, bnd); else pass_cnt++;
        en = 0;
    endtask

    task automatic test_out_of_range();
        lo = 10; hi = 20; step = 1; mode = 0; up = 1;
        do_load(30);
        chk_cnt++; if (q !== 6'd30) $display("FAIL oor_load: got %0d expected 30", q); else pass_cnt++;
        en = 1;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd10, 1'b1}) $display("FAIL oor_up: got q=%0d bnd=%b expected 10 1", q, bnd); else pass_cnt++;
        en = 0;
        do_load(5);
        step = 2; en = 1;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd7, 1'b0}) $display("FAIL oor_toward: got q=%0d bnd=%b expected 7 0", q, bnd); else pass_cnt++;
        en = 0;
    endtask

    task automatic test_priority_cfg();
        lo = 10; hi = 40; step = 1; mode = 0; up = 1;
        do_load(30);
        syn_clr = 1; load = 1; en = 1; d = 33;
        tick();
        syn_clr = 0; load = 0; en = 0;
        chk_cnt++; if ({q, ovf} !== {6'd0, 1'b0}) $display("FAIL prio_clr: got q=%0d ovf=%b expected 0 0", q, ovf); else pass_cnt++;
        lo = 40; hi = 20;
        do_load(30);
        #1;
        chk_cnt++; if (cfg_err !== 1'b1) $display("FAIL cfg_err: got %b expected 1", cfg_err); else pass_cnt++;
        en = 1;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd30, 1'b0}) $display("FAIL cfg_hold: got q=%0d bnd=%b expected 30 0", q, bnd); else pass_cnt++;
        do_load(5);
        chk_cnt++; if (q !== 6'd5) $display("FAIL cfg_load: got %0d expected 5", q); else pass_cnt++;
        en = 0;
        lo = 10; hi = 20;
        #1;
        chk_cnt++; if (cfg_err !== 1'b0) $display("FAIL cfg_ok: got %b expected 0", cfg_err); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        lo = 10; hi = 20; step = 3; mode = 0; up = 1;
        do_load(15);
        en = 1;
        tick(); tick();
        chk_cnt++; if ({q, bnd, ovf} !== {6'd10, 2'b11}) $display("FAIL arst_pre: got q=%0d bnd=%b ovf=%b expected 10 1 1", q, bnd, ovf); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        chk_cnt++; if ({q, bnd, ovf} !== {6'd0, 2'b00}) $display("FAIL arst_mid: got q=%0d bnd=%b ovf=%b expected 0 0 0", q, bnd, ovf); else pass_cnt++;
        tick();
        #2 rst = 1'b0;
        tick();
        chk_cnt++; if ({q, bnd} !== {6'd3, 1'b0}) $display("FAIL arst_resume: got q=%0d bnd=%b expected 3 0", q, bnd); else pass_cnt++;
        en = 0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_up_sat();
        test_down_wrap();
        test_full_range();
        test_out_of_range();
        test_priority_cfg();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
